// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b - bin (mod 2^WIDTH), LSB first,
// one bit per clock, with a borrow-out and a one-cycle done pulse.
//
// state | meaning
// IDLE  | waiting for start; operands captured on accepted start
// SUB   | processing one bit per edge, WIDTH edges total
// DONE  | done=1 for one cycle, result registers hold the new value
module serial_subtractor #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SUB  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] acc;
   logic             br;
   logic [CW-1:0]    cnt;

   logic a_i;
   logic b_i;
   logic d_i;
   logic br_next;

   always_comb begin
      a_i     = a_sh[0];
      b_i     = b_sh[0];
      d_i     = a_i ^ b_i ^ br;
      br_next = (~a_i & b_i) | (~a_i & br) | (b_i & br);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         a_sh  <= '0;
         b_sh  <= '0;
         acc   <= '0;
         br    <= 1'b0;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         diff  <= '0;
         bout  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sh  <= a;
                  b_sh  <= b;
                  br    <= bin;
                  acc   <= '0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= SUB;
               end
            end
            SUB: begin
               // difference bits enter at the MSB so the result lands aligned after WIDTH shifts
               a_sh <= a_sh >> 1;
               b_sh <= b_sh >> 1;
               acc  <= {d_i, acc[WIDTH-1:1]};
               br   <= br_next;
               cnt  <= cnt + 1'b1;
               if (cnt == LAST) begin
                  diff  <= {d_i, acc[WIDTH-1:1]};
                  bout  <= br_next;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized bench for serial_subtractor (WIDTH=4) checked against
// an arithmetic model of a - b - bin.
module tb_serial_subtractor;

   localparam int W = 4;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         bin;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         bout;

   int checks   = 0;
   int failures = 0;

   logic [W-1:0] prev_diff;
   logic         prev_bout;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .bout  (bout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         start = 1'b0;
         check("idle_busy", {31'd0, busy}, 32'd0);
         check("idle_done", {31'd0, done}, 32'd0);
         check("idle_diff_hold", {28'd0, diff}, {28'd0, prev_diff});
         check("idle_bout_hold", {31'd0, bout}, {31'd0, prev_bout});
      end
   endtask

   // garble: 0 = inputs left alone, 1 = zero a/b and re-pulse start, 2 = random noise
   task automatic run_op(input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                         input logic bin_v, input int garble);
      int           full;
      logic [W-1:0] exp_diff;
      logic         exp_bout;
      @(negedge clk);
      check("pre_busy", {31'd0, busy}, 32'd0);
      check("pre_done", {31'd0, done}, 32'd0);
      a     = a_v;
      b     = b_v;
      bin   = bin_v;
      start = 1'b1;
      full     = int'(a_v) - int'(b_v) - int'(bin_v);
      exp_diff = W'(full & ((1 << W) - 1));
      exp_bout = (int'(a_v) < int'(b_v) + int'(bin_v));
      @(posedge clk);
      #1 start = 1'b0;
      for (int i = 0; i < W; i++) begin
         @(negedge clk);
         check("sub_busy", {31'd0, busy}, 32'd1);
         check("sub_done", {31'd0, done}, 32'd0);
         check("sub_diff_hold", {28'd0, diff}, {28'd0, prev_diff});
         check("sub_bout_hold", {31'd0, bout}, {31'd0, prev_bout});
         if (garble == 1) begin
            a     = '0;
            b     = '0;
            start = (i == 1);
         end else if (garble == 2) begin
            a     = W'($urandom);
            b     = W'($urandom);
            bin   = 1'($urandom);
            start = 1'($urandom);
         end
      end
      @(negedge clk);
      check("done_pulse", {31'd0, done}, 32'd1);
      check("done_busy", {31'd0, busy}, 32'd0);
      check("done_diff", {28'd0, diff}, {28'd0, exp_diff});
      check("done_bout", {31'd0, bout}, {31'd0, exp_bout});
      prev_diff = exp_diff;
      prev_bout = exp_bout;
      start = (garble == 2) ? 1'($urandom) : 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      a         = '0;
      b         = '0;
      bin       = 1'b0;
      prev_diff = '0;
      prev_bout = 1'b0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_diff", {28'd0, diff}, 32'd0);
      check("rst_bout", {31'd0, bout}, 32'd0);
      // start held together with reset must not be accepted
      start = 1'b1;
      a     = 4'hF;
      b     = 4'h1;
      @(negedge clk);
      check("rst_start_busy", {31'd0, busy}, 32'd0);
      start = 1'b0;
      rst   = 1'b0;
      idle(2);

      run_op(4'b0011, 4'b0001, 1'b0, 0);
      idle(1);
      run_op(4'b0000, 4'b0001, 1'b0, 0);
      run_op(4'b1001, 4'b0111, 1'b1, 0);
      idle(2);
      run_op(4'b0101, 4'b0101, 1'b1, 0);
      run_op(4'b1111, 4'b0000, 1'b0, 0);
      run_op(4'b1000, 4'b0011, 1'b0, 1);
      idle(3);

      // abort on the second SUB edge
      @(negedge clk);
      a     = 4'hA;
      b     = 4'h3;
      bin   = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      check("abort_busy0", {31'd0, busy}, 32'd1);
      @(negedge clk);
      check("abort_busy1", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      check("abort_diff", {28'd0, diff}, 32'd0);
      check("abort_bout", {31'd0, bout}, 32'd0);
      prev_diff = '0;
      prev_bout = 1'b0;
      idle(6);
      run_op(4'b0110, 4'b0010, 1'b0, 0);

      for (int n = 0; n < 40; n++) begin
         run_op(W'($urandom), W'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0) ? 2 : 0);
         if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
      end
      idle(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand/result width in bits; legal range 2..32.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port a  input  WIDTH  minuend; captured on accepted start.
REQ-006 SHALL have port b  input  WIDTH  subtrahend; captured on accepted start.
REQ-007 SHALL have port bin  input  1  borrow-in; captured on accepted start.
REQ-008 SHALL have port busy  output  1  high while in SUB state.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port diff  output  WIDTH  result, a - b - bin modulo 2^WIDTH.
REQ-011 SHALL have port bout  output  1  borrow-out; 1 when a < b + bin (unsigned).

Function
REQ-012 SHALL implement a three-state FSM: IDLE, SUB, DONE.
REQ-013 IDLE: start=1 at an edge SHALL capture a, b, bin into internal registers, clear the bit counter, and move to SUB; start=0 keeps IDLE.
REQ-014 SUB: each edge SHALL process one bit LSB first; d_i = a_i ^ b_i ^ br; br_next = (~a_i & b_i) | (~a_i & br) | (b_i & br); br initialised to captured bin.
REQ-015 SUB SHALL last exactly WIDTH edges; on the edge processing bit WIDTH-1, FSM SHALL move to DONE and load diff/bout from the completed result in that same edge.
REQ-016 Latency: with start accepted at edge k, done SHALL be high in the cycle following edge k+WIDTH, and diff/bout SHALL be valid from that cycle.
REQ-017 DONE SHALL last exactly one cycle (done=1) then return to IDLE unconditionally.
REQ-018 busy SHALL be 1 in SUB only; done SHALL be 1 in DONE only; both never high together.
REQ-019 start during SUB or DONE SHALL be ignored (no capture, no restart, no queueing); changes on a/b/bin after capture SHALL NOT affect the result.
REQ-020 diff and bout SHALL NOT show partial results; they SHALL hold the last completed result until the next completion or reset.
REQ-021 Result SHALL equal unsigned a - b - bin modulo 2^WIDTH, borrow out of bit WIDTH-1 reported as bout, for all operand values incl. all-zero and all-ones.
REQ-022 Back-to-back operation: start high in the IDLE cycle immediately after DONE SHALL be accepted; minimum spacing between accepted starts is WIDTH+2 edges.

Reset
REQ-023 rst=1 at an edge SHALL force IDLE, busy=0, done=0, diff=0, bout=0, counter and internal operand/borrow registers to 0, with priority over start and all FSM activity.
REQ-024 rst asserted mid-SUB SHALL abort the operation with no done pulse; after release the block SHALL accept a new start normally.
REQ-025 start coincident with rst SHALL be ignored.

Verification (WIDTH=4)
REQ-026 a=0011, b=0001, bin=0, start pulse -> done 4 edges after start edge, diff=0010, bout=0.
REQ-027 a=0000, b=0001, bin=0 -> diff=1111, bout=1; then a=1001, b=0111, bin=1 started in first IDLE cycle after DONE -> diff=0001, bout=0.
REQ-028 a=0101, b=0101, bin=1 -> diff=1111, bout=1; a=1111, b=0000, bin=0 -> diff=1111, bout=0.
REQ-029 Start accepted with a=1000, b=0011; during SUB, start re-pulsed and a/b changed to 0000 -> single done, diff=0101, bout=0, busy continuous for 4 cycles.
REQ-030 Reset asserted on second SUB edge -> next cycle busy=0, done=0, diff=0000, bout=0; no done pulse; subsequent start with a=0110, b=0010 -> diff=0100, bout=0.
REQ-031 Bench SHALL check done is exactly one cycle wide and diff/bout remain stable between completions, against a reference model of a - b - bin.
